seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the processor's combinational ALU.
- Executes single-cycle logic and arithmetic ops, plus iterative unsigned multiply, divide and remainder.
- Uses a Start/Busy/Done handshake. Result and flags are registered and held until the next completion.
- Sits in the execute stage. The controller stalls on Busy.

Parameters:
- W, 8: data width in bits, must be at least 2.
- Ops, 4: opcode width in bits.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  launch op; accepted only in IDLE.
- InputA  in  W  operand A, sampled at accepted Start.
- InputB  in  W  operand B, sampled at accepted Start.
- OP  in  Ops  opcode (op_mne), sampled at accepted Start.
- SC_in  in  1  carry-in for ADD, sampled at accepted Start.
- Out  out  W  result; low product for MUL, quotient for DIV/REM.
- OutHi  out  W  high product for MUL, remainder for DIV/REM, 0 otherwise.
- Busy  out  1  high while an op is in flight.
- Done  out  1  one-cycle pulse when Out/OutHi/flags update.
- Zero  out  1  !(Out), registered.
- Parity  out  1  ^(Out), registered.
- Odd  out  1  Out[0], registered.
- Carry  out  1  ADD carry-out; SUB: 1 = no borrow; 0 for other ops.
- DivZero  out  1  set when DIV/REM has B==0; 0 for other ops.

Behaviour:
- Reset (async, any state, including mid-operation):
  - State returns to IDLE.
  - Out, OutHi, Busy, Done, Carry and DivZero are cleared.
  - Zero=1, Parity=0, Odd=0.
  - Any in-flight op is discarded; Done does not fire for it.
- States and transitions:
  - IDLE: Start with OP in {MUL, DIV, REM} -> ITER. Start with any other OP -> FIN.
  - ITER: runs W cycles, iteration counter 0..W-1. Goes to FIN after count W-1.
  - FIN: registers results, pulses Done, returns to IDLE.
- Busy:
  - Busy=1 in ITER and FIN, and is registered.
  - Start is ignored while Busy, and inputs are not resampled.
  - Start is also ignored in the cycle Done is high, because FIN is still Busy. A back-to-back op can be accepted the cycle after Done.
- Latency (Start edge to Done high):
  - Single-cycle ops: 2 cycles.
  - MUL/DIV/REM: W+2 cycles.
- Single-cycle ops (mod 2^W):
  - ADD: A+B+SC_in; Carry = bit W.
  - SUB: A+~B+1; Carry = bit W.
  - AND: A&B. NOR: ~(A|B). XOR: A^B.
  - LSH: A<<B, true left shift. RSH: A>>B, logical.
  - Shifts with B>=W give 0.
  - SEQ, SNE, SGT, SLT: unsigned compares; result 1 or 0, zero-extended.
  - Unused opcodes: Out=0.
- MUL:
  - Shift-add, one partial product per cycle.
  - {OutHi, Out} = full 2W-bit unsigned product.
- DIV / REM:
  - Restoring division, one quotient bit per cycle.
  - Out = quotient, OutHi = remainder for both opcodes; they differ only in mnemonic.
  - B==0: Out = all ones, OutHi = A, DivZero=1, still W+2 latency.
- Flags:
  - Computed from the final Out.
  - Update only at Done and hold otherwise.
  - Out and OutHi also hold between ops.

Decomposition:
- Package definitions:
  - Extend op_mne: ADD=0, SUB=1, AND=2, NOR=3, XOR=4, LSH=5, RSH=6, SEQ=7, SNE=8, SGT=9, SLT=10, MUL=11, DIV=12, REM=13. Values 14 and 15 are unused.
  - Add typedef alu_state_t {IDLE, ITER, FIN}.
- Sub-module mul_div_iter:
  - Owns the shift registers and iteration counter.
  - Interface: load, mode, done_iter, hi, lo.
- seq_alu keeps the FSM, single-cycle datapath, output and flag registers.

Test Plan:
- W=8, ADD A=200 B=100 SC_in=1 -> Out=45, Carry=1, Zero=0, Odd=1; Done exactly 2 cycles after Start.
- SUB A=5 B=7 -> Out=254, Carry=0; then LSH A=0x81 B=1 -> Out=0x02; then LSH B=8 -> Out=0, Zero=1.
- MUL A=200 B=200 -> Out=0x40, OutHi=0x9C; Busy high 10 cycles; Done 10 cycles after Start; Start pulses while Busy are ignored and leave the result unchanged.
- DIV A=100 B=7 -> Out=14, OutHi=2, DivZero=0; then REM A=100 B=0 -> Out=0xFF, OutHi=100, DivZero=1.
- Reset asserted at cycle 4 of MUL -> all outputs at reset values immediately, no Done. Fresh ADD 1+1 afterwards -> Out=2 with normal latency.
- Back-to-back: Start XOR the cycle after Done of a DIV is accepted; an unused opcode 14 -> Out=0, Zero=1.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared opcode mnemonics, FSM state type and opcode helpers for seq_alu.
package seq_alu_pkg;

    typedef enum logic [3:0] {
        ADD = 4'd0,
        SUB = 4'd1,
        AND = 4'd2,
        NOR = 4'd3,
        XOR = 4'd4,
        LSH = 4'd5,
        RSH = 4'd6,
        SEQ = 4'd7,
        SNE = 4'd8,
        SGT = 4'd9,
        SLT = 4'd10,
        MUL = 4'd11,
        DIV = 4'd12,
        REM = 4'd13
    } op_mne_t;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FIN
    } alu_state_t;

    // Iterator modes: shift-add multiply or restoring divide.
    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;

    // True for the opcodes that run through the W-cycle iterator.
    function automatic logic is_iter_op(input logic [3:0] op);
        return (op == MUL) || (op == DIV) || (op == REM);
    endfunction

endpackage

// File: rtl/seq_alu_mul_div_iter.sv
// Iterative unsigned multiply (shift-add) and divide (restoring), one bit per cycle.
// After W steps: MUL gives {hi, lo} = a*b; DIV gives lo = quotient, hi = remainder.
// A zero divisor naturally yields lo = all ones and hi = a.
module mul_div_iter
    import seq_alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         mode,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         done_iter,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);

    localparam int CW = (W > 2) ? $clog2(W) : 1;

    logic [W-1:0]  r_hi;
    logic [W-1:0]  r_lo;
    logic [W-1:0]  r_b;
    logic          r_mode;
    logic          r_active;
    logic [CW-1:0] r_cnt;

    logic [W:0]    w_add;
    logic [W:0]    w_trial;
    logic [W-1:0]  w_diff;
    logic          w_ge;

    // One step of each algorithm, computed from the current shift registers.
    always_comb begin
        w_add   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
        w_trial = {r_hi, r_lo[W-1]};
        w_ge    = (w_trial >= {1'b0, r_b});
        // Exact whenever w_ge holds, since the partial remainder stays below 2*B.
        w_diff  = w_trial[W-1:0] - r_b;
    end

    // Load operands on a launch, then advance one step per cycle for W cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_mode   <= MODE_MUL;
            r_active <= 1'b0;
            r_cnt    <= '0;
        end else if (load) begin
            r_hi     <= '0;
            r_lo     <= a;
            r_b      <= b;
            r_mode   <= mode;
            r_active <= 1'b1;
            r_cnt    <= '0;
        end else if (r_active) begin
            if (r_mode == MODE_MUL) begin
                r_hi <= w_add[W:1];
                r_lo <= {w_add[0], r_lo[W-1:1]};
            end else begin
                r_hi <= w_ge ? w_diff : w_trial[W-1:0];
                r_lo <= {r_lo[W-2:0], w_ge};
            end
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CW'(W - 1)) begin
                r_active <= 1'b0;
            end
        end
    end

    assign done_iter = r_active && (r_cnt == CW'(W - 1));
    assign hi        = r_hi;
    assign lo        = r_lo;

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU with Start/Busy/Done handshake. Single-cycle ops finish in FIN
// directly; MUL/DIV/REM run W cycles in the iterator first. Results and flags
// are registered in FIN and held until the next completion.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int W   = 8,
    parameter int Ops = 4
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           Start,
    input  logic [W-1:0]   InputA,
    input  logic [W-1:0]   InputB,
    input  logic [Ops-1:0] OP,
    input  logic           SC_in,
    output logic [W-1:0]   Out,
    output logic [W-1:0]   OutHi,
    output logic           Busy,
    output logic           Done,
    output logic           Zero,
    output logic           Parity,
    output logic           Odd,
    output logic           Carry,
    output logic           DivZero
);

    alu_state_t   r_state;
    alu_state_t   w_next;
    logic         r_busy;
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic [3:0]   r_op;
    logic         r_oob;
    logic         r_sc;

    logic [3:0]   w_op;
    logic         w_oob;
    logic         w_iter_op;
    logic         w_accept;
    logic         w_load;
    logic         w_mode;
    logic         w_done_iter;
    logic [W-1:0] w_it_hi;
    logic [W-1:0] w_it_lo;

    logic [W:0]   w_sum;
    logic [W-1:0] w_res;
    logic [W-1:0] w_res_hi;
    logic         w_carry;
    logic         w_dz;

    // Opcodes beyond the 4-bit mnemonic range behave as unused opcodes.
    assign w_op      = 4'(OP);
    assign w_oob     = (OP >> 4) != '0;
    assign w_iter_op = !w_oob && is_iter_op(w_op);
    assign w_accept  = Start && (r_state == IDLE) && !r_busy;
    assign w_load    = w_accept && w_iter_op;
    assign w_mode    = (w_op == MUL) ? MODE_MUL : MODE_DIV;

    mul_div_iter #(.W(W)) u_iter (
        .clk       (Clk),
        .rst       (Reset),
        .load      (w_load),
        .mode      (w_mode),
        .a         (InputA),
        .b         (InputB),
        .done_iter (w_done_iter),
        .hi        (w_it_hi),
        .lo        (w_it_lo)
    );

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = w_iter_op ? ITER : FIN;
            ITER:    if (w_done_iter) w_next = FIN;
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Busy covers the op and the Done cycle, so a new Start lands the cycle after Done.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= w_accept || (r_state != IDLE);
        end
    end

    // Capture operands and opcode at an accepted Start.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_a   <= '0;
            r_b   <= '0;
            r_op  <= '0;
            r_oob <= 1'b0;
            r_sc  <= 1'b0;
        end else if (w_accept) begin
            r_a   <= InputA;
            r_b   <= InputB;
            r_op  <= w_op;
            r_oob <= w_oob;
            r_sc  <= SC_in;
        end
    end

    // Result selection: single-cycle datapath or iterator outputs.
    always_comb begin
        w_sum    = '0;
        w_res    = '0;
        w_res_hi = '0;
        w_carry  = 1'b0;
        w_dz     = 1'b0;
        if (!r_oob) begin
            case (r_op)
                ADD: begin
                    w_sum   = {1'b0, r_a} + {1'b0, r_b} + {{W{1'b0}}, r_sc};
                    w_res   = w_sum[W-1:0];
                    w_carry = w_sum[W];
                end
                SUB: begin
                    w_sum   = {1'b0, r_a} + {1'b0, ~r_b} + {{W{1'b0}}, 1'b1};
                    w_res   = w_sum[W-1:0];
                    w_carry = w_sum[W];
                end
                AND: w_res = r_a & r_b;
                NOR: w_res = ~(r_a | r_b);
                XOR: w_res = r_a ^ r_b;
                LSH: w_res = r_a << r_b;
                RSH: w_res = r_a >> r_b;
                SEQ: w_res = {{(W-1){1'b0}}, (r_a == r_b)};
                SNE: w_res = {{(W-1){1'b0}}, (r_a != r_b)};
                SGT: w_res = {{(W-1){1'b0}}, (r_a > r_b)};
                SLT: w_res = {{(W-1){1'b0}}, (r_a < r_b)};
                MUL: begin
                    w_res    = w_it_lo;
                    w_res_hi = w_it_hi;
                end
                DIV, REM: begin
                    w_res    = w_it_lo;
                    w_res_hi = w_it_hi;
                    w_dz     = (r_b == '0);
                end
                default: w_res = '0;
            endcase
        end
    end

    // Output and flag registers: update in FIN, hold otherwise.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Out     <= '0;
            OutHi   <= '0;
            Done    <= 1'b0;
            Zero    <= 1'b1;
            Parity  <= 1'b0;
            Odd     <= 1'b0;
            Carry   <= 1'b0;
            DivZero <= 1'b0;
        end else begin
            Done <= (r_state == FIN);
            if (r_state == FIN) begin
                Out     <= w_res;
                OutHi   <= w_res_hi;
                Zero    <= ~|w_res;
                Parity  <= ^w_res;
                Odd     <= w_res[0];
                Carry   <= w_carry;
                DivZero <= w_dz;
            end
        end
    end

    assign Busy = r_busy;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (W=8): arithmetic reference model with
// latency/acceptance bookkeeping, a per-cycle compare, and literal expectations.
module tb_seq_alu;
    import seq_alu_pkg::*;

    localparam int W = 8;

    logic         Clk = 1'b0;
    logic         Reset = 1'b1;
    logic         Start = 1'b0;
    logic [W-1:0] InputA = '0;
    logic [W-1:0] InputB = '0;
    logic [3:0]   OP = '0;
    logic         SC_in = 1'b0;
    logic [W-1:0] Out;
    logic [W-1:0] OutHi;
    logic         Busy;
    logic         Done;
    logic         Zero;
    logic         Parity;
    logic         Odd;
    logic         Carry;
    logic         DivZero;

    int n_tests = 0;
    int n_fail  = 0;
    logic chk_en = 1'b0;

    seq_alu #(.W(W), .Ops(4)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Start   (Start),
        .InputA  (InputA),
        .InputB  (InputB),
        .OP      (OP),
        .SC_in   (SC_in),
        .Out     (Out),
        .OutHi   (OutHi),
        .Busy    (Busy),
        .Done    (Done),
        .Zero    (Zero),
        .Parity  (Parity),
        .Odd     (Odd),
        .Carry   (Carry),
        .DivZero (DivZero)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference arithmetic straight from the op definitions.
    function automatic void model_calc(input int op, input int a, input int b, input int sc,
                                       output int o, output int h, output int c, output int dz);
        longint mask = (64'd1 << W) - 1;
        longint s;
        o = 0; h = 0; c = 0; dz = 0;
        case (op)
            0:  begin s = a + b + sc; o = int'(s & mask); c = int'((s >> W) & 1); end
            1:  begin o = int'((a - b) & mask); c = (a >= b) ? 1 : 0; end
            2:  o = a & b;
            3:  o = int'(~(a | b) & mask);
            4:  o = a ^ b;
            5:  o = (b >= W) ? 0 : int'((longint'(a) << b) & mask);
            6:  o = (b >= W) ? 0 : (a >> b);
            7:  o = (a == b) ? 1 : 0;
            8:  o = (a != b) ? 1 : 0;
            9:  o = (a > b) ? 1 : 0;
            10: o = (a < b) ? 1 : 0;
            11: begin s = longint'(a) * longint'(b); o = int'(s & mask); h = int'(s >> W); end
            12, 13: begin
                if (b == 0) begin o = int'(mask); h = a; dz = 1; end
                else begin o = a / b; h = a % b; end
            end
            default: o = 0;
        endcase
    endfunction

    // Model: edges since last accepted op, latency, and expected held outputs.
    int m_age = 1000;
    int m_lat = 2;
    int p_out, p_hi, p_c, p_dz;
    logic [W-1:0] e_out = '0;
    logic [W-1:0] e_hi = '0;
    logic e_busy = 1'b0, e_done = 1'b0, e_zero = 1'b1, e_par = 1'b0, e_odd = 1'b0;
    logic e_carry = 1'b0, e_dz = 1'b0;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            m_age = 1000; e_out = '0; e_hi = '0; e_busy = 1'b0; e_done = 1'b0;
            e_zero = 1'b1; e_par = 1'b0; e_odd = 1'b0; e_carry = 1'b0; e_dz = 1'b0;
        end else begin
            if (m_age < 1000) m_age++;
            if (Start && m_age > m_lat) begin
                m_age = 0;
                m_lat = (int'(OP) >= 11 && int'(OP) <= 13) ? W + 2 : 2;
                model_calc(int'(OP), int'(InputA), int'(InputB), int'(SC_in), p_out, p_hi, p_c, p_dz);
            end
            e_busy = (m_age <= m_lat - 1);
            e_done = (m_age == m_lat - 1);
            if (e_done) begin
                e_out = W'(p_out); e_hi = W'(p_hi); e_carry = p_c[0]; e_dz = p_dz[0];
                e_zero = (e_out == '0); e_par = ^e_out; e_odd = e_out[0];
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge Clk) begin
        if (chk_en && !Reset) begin
            check("cycle", {Busy, Done, Zero, Parity, Odd, Carry, DivZero, OutHi, Out},
                  {e_busy, e_done, e_zero, e_par, e_odd, e_carry, e_dz, e_hi, e_out});
        end
    end

    // Launch one op and wait (bounded) for Done; inputs are scrambled after accept.
    task automatic run(input int op, input int a, input int b, input int sc, output int lat);
        @(posedge Clk); #1;
        OP = 4'(op); InputA = 8'(a); InputB = 8'(b); SC_in = sc[0]; Start = 1'b1;
        lat = 0;
        do begin
            @(posedge Clk); #1;
            Start = 1'b0; InputA = ~InputA; InputB = ~InputB; SC_in = ~SC_in;
            lat++;
        end while (!Done && lat < 40);
        check("done_seen", Done, 1'b1);
    endtask

    int lat, busy_n;
    logic saw_done;
    int t_op[11]  = '{AND, NOR, RSH, RSH, SEQ, SNE, SGT, SLT, LSH, MUL, DIV};
    int t_a[11]   = '{'hF0, 'hF0, 'h80, 'h80, 5, 5, 200, 200, 1, 255, 255};
    int t_b[11]   = '{'h3C, 'h0C, 7, 9, 5, 5, 100, 100, 7, 255, 16};
    int t_lo[11]  = '{'h30, 'h03, 1, 0, 1, 0, 1, 0, 'h80, 'h01, 15};
    int t_hi[11]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 'hFE, 15};

    initial begin
        #12;
        check("rst_out", {Out, OutHi, Busy, Done, Zero, Parity, Odd, Carry, DivZero},
              {8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        @(negedge Clk); Reset = 1'b0; chk_en = 1'b1;

        run(ADD, 200, 100, 1, lat);
        check("add_lat", lat, 2);
        check("add_out", {Out, Carry, Zero, Odd}, {8'd45, 1'b1, 1'b0, 1'b1});

        run(SUB, 5, 7, 0, lat);
        check("sub_out", {Out, Carry}, {8'd254, 1'b0});
        run(LSH, 'h81, 1, 0, lat);
        check("lsh1", Out, 8'h02);
        run(LSH, 'h81, 8, 0, lat);
        check("lsh8", {Out, Zero}, {8'h00, 1'b1});

        // MUL with Start pulses while busy and during the Done cycle.
        @(posedge Clk); #1;
        OP = 4'(MUL); InputA = 8'd200; InputB = 8'd200; Start = 1'b1;
        lat = 0; busy_n = 0;
        do begin
            @(posedge Clk); #1;
            lat++;
            if (Busy) busy_n++;
            if (lat == 3 || lat == 5) begin
                Start = 1'b1; OP = 4'(ADD); InputA = 8'd1; InputB = 8'd1;
            end else begin
                Start = 1'b0;
            end
        end while (!Done && lat < 40);
        check("mul_done", Done, 1'b1);
        check("mul_lat", lat, 10);
        check("mul_out", {OutHi, Out}, {8'h9C, 8'h40});
        Start = 1'b1; OP = 4'(ADD); InputA = 8'd3; InputB = 8'd3;
        @(posedge Clk); #1;
        Start = 1'b0;
        if (Busy) busy_n++;
        check("mul_busy_cycles", busy_n, 10);
        check("done_cycle_start_ignored", Busy, 1'b0);
        @(posedge Clk); #1;
        check("mul_held", {Done, OutHi, Out}, {1'b0, 8'h9C, 8'h40});

        run(DIV, 100, 7, 0, lat);
        check("div_out", {Out, OutHi, DivZero}, {8'd14, 8'd2, 1'b0});
        check("div_lat", lat, 10);
        run(REM, 100, 0, 0, lat);
        check("rem_dz", {Out, OutHi, DivZero}, {8'hFF, 8'd100, 1'b1});

        // Reset in the middle of a MUL.
        @(posedge Clk); #1;
        OP = 4'(MUL); InputA = 8'd13; InputB = 8'd11; Start = 1'b1;
        @(posedge Clk); #1; Start = 1'b0;
        @(posedge Clk); @(posedge Clk); @(posedge Clk); #2;
        Reset = 1'b1; #1;
        check("mid_rst", {Out, OutHi, Busy, Done, Zero, Parity, Odd, Carry, DivZero},
              {8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        @(posedge Clk); #2; Reset = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge Clk); #1;
            if (Done) saw_done = 1'b1;
        end
        check("no_done_after_rst", saw_done, 1'b0);
        run(ADD, 1, 1, 0, lat);
        check("post_rst_add", {Out, 8'(lat)}, {8'd2, 8'd2});

        // Back-to-back: XOR the cycle after a DIV Done, then an unused opcode.
        run(DIV, 200, 9, 0, lat);
        check("div2", {Out, OutHi}, {8'd22, 8'd2});
        run(XOR, 'hF0, 'h3C, 0, lat);
        check("b2b_xor", {Out, 8'(lat)}, {8'hCC, 8'd2});
        run(14, 5, 3, 0, lat);
        check("unused_op", {Out, OutHi, Zero}, {8'h00, 8'h00, 1'b1});

        for (int i = 0; i < 11; i++) begin
            run(t_op[i], t_a[i], t_b[i], 0, lat);
            check($sformatf("vec%0d", i), {OutHi, Out}, {8'(t_hi[i]), 8'(t_lo[i])});
        end

        repeat (3) @(posedge Clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
